// File: rtl/data_cache_if.sv
//------------------------------------------------------------------------------
// Module      : data_cache_if
// Description : MEM-stage request bus and line-granular backing-memory bus of
//               the data cache, bundled with master/slave views.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface data_cache_if #(
  parameter int LINE_WORDS = 4
);
  // MEM-stage side
  logic                    is_input_valid;
  logic [31:0]             addr;
  logic                    mem_rw;
  logic [31:0]             din;
  logic                    is_ready;
  logic                    is_output_valid;
  logic [31:0]             dout;
  logic                    is_hit;
  // backing-memory side
  logic                    mem_req;
  logic                    mem_we;
  logic [31:0]             mem_addr;
  logic [32*LINE_WORDS-1:0] mem_wdata;
  logic                    mem_ack;
  logic [32*LINE_WORDS-1:0] mem_rdata;

  // slave: the cache itself
  modport slave (
    input  is_input_valid, addr, mem_rw, din, mem_ack, mem_rdata,
    output is_ready, is_output_valid, dout, is_hit,
           mem_req, mem_we, mem_addr, mem_wdata
  );

  // master: pipeline plus backing memory driving the cache
  modport master (
    output is_input_valid, addr, mem_rw, din, mem_ack, mem_rdata,
    input  is_ready, is_output_valid, dout, is_hit,
           mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

`default_nettype wire

// File: rtl/data_cache.sv
//------------------------------------------------------------------------------
// Module      : data_cache
// Description : Direct-mapped, write-back, write-allocate data cache.
//               Optional hit/miss counters under macro DCACHE_STATS_EN.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module data_cache #(
  parameter int NUM_SETS   = 16,
  parameter int LINE_WORDS = 4
) (
  input  wire logic       clk,
  input  wire logic       reset,
  data_cache_if.slave     bus
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]     hit_count,
  output logic [31:0]     miss_count
`endif
);

  localparam int c_WORD_W = $clog2(LINE_WORDS);
  localparam int c_OFF_W  = c_WORD_W + 2;
  localparam int c_IDX_W  = $clog2(NUM_SETS);
  localparam int c_TAG_W  = 32 - c_OFF_W - c_IDX_W;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOOKUP    = 2'd1,
    WRITEBACK = 2'd2,
    ALLOCATE  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic [31:2]               r_addr;
  logic                      r_rw;
  logic [31:0]               r_din;
  logic                      r_miss;

  logic [NUM_SETS-1:0]       r_valid;
  logic [NUM_SETS-1:0]       r_dirty;
  logic [c_TAG_W-1:0]        r_tag  [NUM_SETS];
  logic [LINE_WORDS-1:0][31:0] r_data [NUM_SETS];

  logic [c_IDX_W-1:0]        w_idx;
  logic [c_TAG_W-1:0]        w_tag;
  logic [c_WORD_W-1:0]       w_word;
  logic                      w_hit;
  logic                      w_accept;
  logic                      w_store_hit;
  logic                      w_fill;
  logic                      w_set_miss;
  logic                      w_unused;

  assign w_idx    = r_addr[c_OFF_W +: c_IDX_W];
  assign w_tag    = r_addr[31 -: c_TAG_W];
  assign w_word   = r_addr[c_OFF_W-1:2];
  assign w_hit    = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_unused = &{1'b0, bus.addr[1:0]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state        = r_state;
    w_accept            = 1'b0;
    w_store_hit         = 1'b0;
    w_fill              = 1'b0;
    w_set_miss          = 1'b0;
    bus.is_ready        = 1'b0;
    bus.is_output_valid = 1'b0;
    bus.dout            = '0;
    bus.is_hit          = 1'b0;
    bus.mem_req         = 1'b0;
    bus.mem_we          = 1'b0;
    bus.mem_addr        = '0;
    bus.mem_wdata       = '0;
    case (r_state)
      IDLE: begin
        bus.is_ready = 1'b1;
        if (bus.is_input_valid) begin
          w_accept     = 1'b1;
          w_next_state = LOOKUP;
        end
      end
      LOOKUP: begin
        if (w_hit) begin
          bus.is_output_valid = 1'b1;
          bus.is_hit          = !r_miss;
          if (r_rw) begin
            w_store_hit = 1'b1;
          end else begin
            bus.dout = r_data[w_idx][w_word];
          end
          w_next_state = IDLE;
        end else begin
          w_set_miss   = 1'b1;
          w_next_state = (r_valid[w_idx] && r_dirty[w_idx]) ? WRITEBACK : ALLOCATE;
        end
      end
      WRITEBACK: begin
        // Victim line is untouched until the fill, so address/data hold steady.
        bus.mem_req   = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = {r_tag[w_idx], w_idx, {c_OFF_W{1'b0}}};
        bus.mem_wdata = r_data[w_idx];
        if (bus.mem_ack) begin
          w_next_state = ALLOCATE;
        end
      end
      ALLOCATE: begin
        bus.mem_req  = 1'b1;
        bus.mem_addr = {w_tag, w_idx, {c_OFF_W{1'b0}}};
        if (bus.mem_ack) begin
          w_fill       = 1'b1;
          w_next_state = LOOKUP;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_addr  <= '0;
      r_rw    <= 1'b0;
      r_din   <= '0;
      r_miss  <= 1'b0;
      r_valid <= '0;
      r_dirty <= '0;
    end else begin
      if (w_accept) begin
        r_addr <= bus.addr[31:2];
        r_rw   <= bus.mem_rw;
        r_din  <= bus.din;
        r_miss <= 1'b0;
      end
      if (w_set_miss) begin
        r_miss <= 1'b1;
      end
      if (w_store_hit) begin
        r_dirty[w_idx] <= 1'b1;
      end
      if (w_fill) begin
        r_valid[w_idx] <= 1'b1;
        r_dirty[w_idx] <= 1'b0;
      end
    end
  end

  // Tag and data storage carry no reset; the valid bits qualify them.
  always_ff @(posedge clk) begin
    if (w_store_hit) begin
      r_data[w_idx][w_word] <= r_din;
    end
    if (w_fill) begin
      r_data[w_idx] <= bus.mem_rdata;
      r_tag[w_idx]  <= w_tag;
    end
  end

`ifdef DCACHE_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (bus.is_output_valid) begin
      if (bus.is_hit) begin
        hit_count <= hit_count + 32'd1;
      end else begin
        miss_count <= miss_count + 32'd1;
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_data_cache.sv
//------------------------------------------------------------------------------
// Module      : tb_data_cache
// Description : Directed self-checking bench for data_cache with a behavioural
//               line memory that acknowledges 3 cycles after each request.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_data_cache;

  localparam int c_ACK_DLY = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  data_cache_if #(.LINE_WORDS(4)) bus ();

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  data_cache #(
    .NUM_SETS   (16),
    .LINE_WORDS (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus)
`ifdef DCACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  logic [127:0] mem_model [logic [31:0]];
  int           wb_cnt;
  int           fill_cnt;
  logic [31:0]  last_wb_addr;
  logic [127:0] last_wb_data;
  logic [31:0]  last_fill_addr;

  logic [31:0]  rd;
  logic         hit;
  int           lat;
  int           first_req_lat;
  int           fill_gap;
  int           viol;
  logic         rdy_at_valid;
  logic         rdy_after;
  int           extra;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [127:0] line_of(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return {a + 32'd3, a + 32'd2, a + 32'd1, a};
  endfunction

  // One MEM-stage access, serving the memory port until completion.
  task automatic access(input logic rw, input logic [31:0] a, input logic [31:0] d,
                        input bit hold);
    int           n;
    int           req_cnt;
    int           wb_ack_cyc;
    bit           in_req;
    bit           fill_acked;
    bit           done;
    logic         l_we;
    logic [31:0]  l_addr;
    logic [127:0] l_wdata;
    viol          = 0;
    first_req_lat = -1;
    fill_gap      = -1;
    wb_ack_cyc    = -1;
    in_req        = 0;
    fill_acked    = 0;
    done          = 0;
    req_cnt       = 0;
    bus.is_input_valid = 1'b1;
    bus.addr           = a;
    bus.mem_rw         = rw;
    bus.din            = d;
    n = cyc;
    tick();
    if (!hold) bus.is_input_valid = 1'b0;
    for (int k = 0; k < 300 && !done; k++) begin
      if (hold && bus.is_input_valid) begin
        bus.addr   = a + 32'h1000 * (k + 1);
        bus.mem_rw = ~bus.mem_rw;
        bus.din    = bus.din + 32'd1;
      end
      if (fill_acked && bus.mem_req) viol++;
      fill_acked = 0;
      if (bus.mem_req) begin
        if (!in_req) begin
          in_req  = 1;
          req_cnt = 0;
          l_we    = bus.mem_we;
          l_addr  = bus.mem_addr;
          l_wdata = bus.mem_wdata;
          if (first_req_lat < 0) first_req_lat = cyc - n;
          if (!bus.mem_we && wb_ack_cyc >= 0) fill_gap = cyc - wb_ack_cyc;
        end else if (bus.mem_we !== l_we || bus.mem_addr !== l_addr ||
                     bus.mem_wdata !== l_wdata) begin
          viol++;
        end
        if (req_cnt == c_ACK_DLY) begin
          bus.mem_ack = 1'b1;
          if (bus.mem_we) begin
            wb_cnt++;
            last_wb_addr = bus.mem_addr;
            last_wb_data = bus.mem_wdata;
            mem_model[bus.mem_addr] = bus.mem_wdata;
            wb_ack_cyc = cyc;
          end else begin
            fill_cnt++;
            last_fill_addr = bus.mem_addr;
            bus.mem_rdata  = line_of(bus.mem_addr);
            fill_acked     = 1;
          end
          in_req = 0;
        end else begin
          bus.mem_ack = 1'b0;
        end
        req_cnt++;
      end else begin
        bus.mem_ack = 1'b0;
        in_req      = 0;
      end
      if (bus.is_output_valid) begin
        rd                 = bus.dout;
        hit                = bus.is_hit;
        lat                = cyc - n;
        rdy_at_valid       = bus.is_ready;
        bus.is_input_valid = 1'b0;
        done               = 1;
      end else begin
        tick();
      end
    end
    check("access_done", done, 1'b1);
    bus.mem_ack = 1'b0;
    tick();
    rdy_after = bus.is_ready;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset              = 1'b0;
    bus.is_input_valid = 1'b0;
    bus.addr           = '0;
    bus.mem_rw         = 1'b0;
    bus.din            = '0;
    bus.mem_ack        = 1'b0;
    bus.mem_rdata      = '0;
    wb_cnt             = 0;
    fill_cnt           = 0;
    last_wb_addr       = '0;
    last_wb_data       = '0;
    last_fill_addr     = '0;
    mem_model[32'h40]  = {32'd4, 32'd3, 32'd2, 32'd1};
    mem_model[32'h140] = {32'd8, 32'd7, 32'd6, 32'd5};

    repeat (3) tick();
    check("rst_ready",    bus.is_ready, 1'b1);
    check("rst_valid",    bus.is_output_valid, 1'b0);
    check("rst_req",      bus.mem_req, 1'b0);
    check("rst_dout",     bus.dout, 32'h0);
    check("rst_mem_addr", bus.mem_addr, 32'h0);
`ifdef DCACHE_STATS_EN
    check("rst_hit_count",  hit_count, 32'h0);
    check("rst_miss_count", miss_count, 32'h0);
`endif
    @(negedge clk);
    reset = 1'b1;
    tick();

    // Cold load miss
    access(1'b0, 32'h40, 32'h0, 1'b0);
    check("cold_dout",      rd, 32'd1);
    check("cold_hit",       hit, 1'b0);
    check("cold_req_lat",   first_req_lat, 32'd2);
    check("cold_fill_addr", last_fill_addr, 32'h40);
    check("cold_no_wb",     wb_cnt, 32'd0);
    check("cold_stable",    viol, 32'd0);

    // Store hit then load back
    access(1'b1, 32'h44, 32'hDEADBEEF, 1'b0);
    check("st_hit",       hit, 1'b1);
    check("st_lat",       lat, 32'd1);
    check("st_dout",      rd, 32'h0);
    check("st_rdy_valid", rdy_at_valid, 1'b0);
    check("st_rdy_after", rdy_after, 1'b1);
    check("st_no_fill",   fill_cnt, 32'd1);
    access(1'b0, 32'h44, 32'h0, 1'b0);
    check("ld44_dout", rd, 32'hDEADBEEF);
    check("ld44_hit",  hit, 1'b1);
    check("ld44_lat",  lat, 32'd1);
    access(1'b0, 32'h48, 32'h0, 1'b0);
    check("ld48_dout", rd, 32'd3);

    // Conflict eviction of the dirty line
    access(1'b0, 32'h140, 32'h0, 1'b0);
    check("ev_wb_cnt",    wb_cnt, 32'd1);
    check("ev_wb_addr",   last_wb_addr, 32'h40);
    check("ev_wb_word0",  last_wb_data[31:0], 32'd1);
    check("ev_wb_word1",  last_wb_data[63:32], 32'hDEADBEEF);
    check("ev_fill_addr", last_fill_addr, 32'h140);
    check("ev_fill_gap",  fill_gap, 32'd1);
    check("ev_req_lat",   first_req_lat, 32'd2);
    check("ev_dout",      rd, 32'd5);
    check("ev_hit",       hit, 1'b0);
    check("ev_stable",    viol, 32'd0);

    // Requests held during a miss are ignored
    access(1'b0, 32'h240, 32'h0, 1'b1);
    check("ign_dout",      rd, 32'h240);
    check("ign_hit",       hit, 1'b0);
    check("ign_fill_cnt",  fill_cnt, 32'd3);
    check("ign_fill_addr", last_fill_addr, 32'h240);
    check("ign_wb_cnt",    wb_cnt, 32'd1);
    extra = 0;
    bus.mem_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (bus.is_output_valid || bus.mem_req || !bus.is_ready) extra++;
      tick();
    end
    bus.mem_ack = 1'b0;
    check("ign_idle_ack", extra, 32'd0);
    access(1'b0, 32'h244, 32'h0, 1'b0);
    check("ign_after_hit",  hit, 1'b1);
    check("ign_after_dout", rd, 32'h241);

    // Reset while the fill is outstanding
    bus.is_input_valid = 1'b1;
    bus.addr           = 32'h340;
    bus.mem_rw         = 1'b0;
    tick();
    bus.is_input_valid = 1'b0;
    extra = 0;
    for (int i = 0; i < 10 && !bus.mem_req; i++) tick();
    check("rm_req_seen", bus.mem_req, 1'b1);
    tick();
    #2;
    reset = 1'b0;
    #1;
    check("rm_req_drop", bus.mem_req, 1'b0);
    check("rm_ready",    bus.is_ready, 1'b1);
`ifdef DCACHE_STATS_EN
    check("rm_hit_count",  hit_count, 32'h0);
    check("rm_miss_count", miss_count, 32'h0);
`endif
    @(negedge clk);
    reset = 1'b1;
    tick();
    access(1'b0, 32'h340, 32'h0, 1'b0);
    check("rm_miss", hit, 1'b0);
    check("rm_dout", rd, 32'h340);

    // Miss, hit, hit, miss after reset
    access(1'b0, 32'h340, 32'h0, 1'b0);
    check("seq_hit1", hit, 1'b1);
    access(1'b1, 32'h344, 32'h12345678, 1'b0);
    check("seq_hit2", hit, 1'b1);
    access(1'b0, 32'h44, 32'h0, 1'b0);
    check("seq_miss_hit",   hit, 1'b0);
    check("seq_miss_dout",  rd, 32'hDEADBEEF);
    check("seq_wb_addr",    last_wb_addr, 32'h340);
    check("seq_wb_word1",   last_wb_data[63:32], 32'h12345678);
`ifdef DCACHE_STATS_EN
    check("stats_hits",   hit_count, 32'd2);
    check("stats_misses", miss_count, 32'd2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
